// File: rtl/shift_reg_checker.sv
// Golden-model monitor for the 4-bit shift/rotate/load register.
// Ports: clk, rst_n, chk_clr, enb/dir/s_in/mode/d (register controls),
//   dut_q/dut_s_out (register outputs); chk_active, err_pulse, fail,
//   err_cnt, chk_cnt, first_exp_q, first_act_q (check results).
module shift_reg_checker #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_clr,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] dut_q,
    input  logic             dut_s_out,
    output logic             chk_active,
    output logic             err_pulse,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CYC_W-1:0] chk_cnt,
    output logic [WIDTH-1:0] first_exp_q,
    output logic [WIDTH-1:0] first_act_q
);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        SYNC_S = 2'd1,
        CHECK  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mq;
    logic             ms;
    logic             is_load;
    logic             is_shift;
    logic             cmp_en;
    logic             mismatch;

    assign is_load  = enb && (mode == 2'b10);
    assign is_shift = enb && !mode[1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNSYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a clear overrides any load or shift
    always_comb begin
        state_nxt = state;
        if (chk_clr) begin
            state_nxt = UNSYNC;
        end else begin
            unique case (state)
                UNSYNC:  if (is_load) state_nxt = SYNC_S;
                SYNC_S:  if (is_shift) state_nxt = CHECK;
                CHECK:   state_nxt = CHECK;
                default: state_nxt = UNSYNC;
            endcase
        end
    end

    // Compare against the model; s_out is unknown until the first
    // shift/rotate after sync. Case inequality flags X/Z as a miss.
    always_comb begin
        cmp_en     = (state != UNSYNC);
        chk_active = cmp_en;
        mismatch   = 1'b0;
        if (cmp_en) begin
            mismatch = (dut_q !== mq);
            if (state == CHECK && (dut_s_out !== ms)) begin
                mismatch = 1'b1;
            end
        end
    end

    // Golden register model
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq <= '0;
            ms <= 1'b0;
        end else if (enb) begin
            unique case (mode)
                2'b00: begin
                    if (dir) begin
                        mq <= {s_in, mq[WIDTH-1:1]};
                        ms <= mq[0];
                    end else begin
                        mq <= {mq[WIDTH-2:0], s_in};
                        ms <= mq[WIDTH-1];
                    end
                end
                2'b01: begin
                    if (dir) begin
                        mq <= {mq[0], mq[WIDTH-1:1]};
                        ms <= mq[0];
                    end else begin
                        mq <= {mq[WIDTH-2:0], mq[WIDTH-1]};
                        ms <= mq[WIDTH-1];
                    end
                end
                2'b10:   mq <= d;
                default: ;
            endcase
        end
    end

    // Registered results, one cycle after the compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse   <= 1'b0;
            fail        <= 1'b0;
            err_cnt     <= '0;
            chk_cnt     <= '0;
            first_exp_q <= '0;
            first_act_q <= '0;
        end else if (chk_clr) begin
            err_pulse   <= 1'b0;
            fail        <= 1'b0;
            err_cnt     <= '0;
            chk_cnt     <= '0;
            first_exp_q <= '0;
            first_act_q <= '0;
        end else begin
            err_pulse <= mismatch;
            if (mismatch) begin
                fail <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
                if (!fail) begin
                    first_exp_q <= mq;
                    first_act_q <= dut_q;
                end
            end
            if (cmp_en && chk_cnt != '1) begin
                chk_cnt <= chk_cnt + CYC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_checker.sv
// Directed bench for shift_reg_checker.
// Drives controls and fake register outputs, checks result ports.
module tb_shift_reg_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       chk_clr = 1'b0;
    logic       enb = 1'b0;
    logic       dir = 1'b0;
    logic       s_in = 1'b0;
    logic [1:0] mode = 2'b11;
    logic [3:0] d = 4'b0000;
    logic [3:0] dut_q = 4'b0000;
    logic       dut_s_out = 1'b0;

    logic        chk_active, err_pulse, fail;
    logic [7:0]  err_cnt;
    logic [15:0] chk_cnt;
    logic [3:0]  first_exp_q, first_act_q;

    logic        chk_active2, err_pulse2, fail2;
    logic [1:0]  err_cnt2;
    logic [15:0] chk_cnt2;
    logic [3:0]  first_exp_q2, first_act_q2;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] SH = 2'b00;
    localparam logic [1:0] RO = 2'b01;
    localparam logic [1:0] LD = 2'b10;
    localparam logic [1:0] HO = 2'b11;

    always #5 clk = ~clk;

    shift_reg_checker u_dut (
        .clk(clk), .rst_n(rst_n), .chk_clr(chk_clr),
        .enb(enb), .dir(dir), .s_in(s_in), .mode(mode), .d(d),
        .dut_q(dut_q), .dut_s_out(dut_s_out),
        .chk_active(chk_active), .err_pulse(err_pulse), .fail(fail),
        .err_cnt(err_cnt), .chk_cnt(chk_cnt),
        .first_exp_q(first_exp_q), .first_act_q(first_act_q)
    );

    shift_reg_checker #(.ERR_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .chk_clr(chk_clr),
        .enb(enb), .dir(dir), .s_in(s_in), .mode(mode), .d(d),
        .dut_q(dut_q), .dut_s_out(dut_s_out),
        .chk_active(chk_active2), .err_pulse(err_pulse2), .fail(fail2),
        .err_cnt(err_cnt2), .chk_cnt(chk_cnt2),
        .first_exp_q(first_exp_q2), .first_act_q(first_act_q2)
    );

    // One cycle: controls for the coming edge, register outputs for
    // the current cycle. Returns at the following falling edge.
    task automatic cyc(input logic c, input logic e, input logic dr,
                       input logic si, input logic [1:0] m,
                       input logic [3:0] dd, input logic [3:0] qv,
                       input logic so);
        chk_clr   = c;
        enb       = e;
        dir       = dr;
        s_in      = si;
        mode      = m;
        d         = dd;
        dut_q     = qv;
        dut_s_out = so;
        @(negedge clk);
    endtask

    task automatic clr();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b0000, 1'b0);
        chk_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({chk_active, err_pulse, fail, err_cnt, chk_cnt, first_exp_q, first_act_q} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got act=%b ep=%b f=%b ec=%0d cc=%0d want all 0",
                     chk_active, err_pulse, fail, err_cnt, chk_cnt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, i[0], SH, 4'b0000, 4'b0110, 1'b1);
        end
        n_cmp++;
        if (chk_active !== 1'b0 || err_cnt !== 8'd0 || chk_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL no_load_unsync: got act=%b ec=%0d cc=%0d want 0/0/0",
                     chk_active, err_cnt, chk_cnt);
        end
    endtask

    task automatic test_shift_left();
        logic [3:0] eq [5];
        logic       es [5];
        eq = '{4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111};
        es = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        clr();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, LD, 4'b1010, 4'b0000, 1'b0);
        n_cmp++;
        if (chk_active !== 1'b1) begin
            n_bad++;
            $display("FAIL sync_after_load: got %b want 1", chk_active);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, i < 4, 1'b0, 1'b1, i < 4 ? SH : HO, 4'b0000, eq[i], es[i]);
            n_cmp++;
            if (err_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL shl_pulse[%0d]: got %b want 0", i, err_pulse);
            end
        end
        n_cmp++;
        if (err_cnt !== 8'd0 || fail !== 1'b0 || chk_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL shl_counts: got ec=%0d f=%b cc=%0d want 0/0/5",
                     err_cnt, fail, chk_cnt);
        end
    endtask

    task automatic test_rotate_right();
        logic [3:0] eq [5];
        logic       es [5];
        eq = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        es = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        clr();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, LD, 4'b0001, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, i < 4, 1'b1, 1'b0, i < 4 ? RO : HO, 4'b0000, eq[i], es[i]);
        end
        n_cmp++;
        if (err_cnt !== 8'd0 || fail !== 1'b0 || chk_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL ror_counts: got ec=%0d f=%b cc=%0d want 0/0/5",
                     err_cnt, fail, chk_cnt);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b0001, 1'b1);
        n_cmp++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL sout_fault: got ep=%b ec=%0d want 1/1", err_pulse, err_cnt);
        end
    endtask

    task automatic test_fault_capture();
        clr();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, LD, 4'b1010, 4'b0000, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b1011, 1'b0);
        n_cmp++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || fail !== 1'b1) begin
            n_bad++;
            $display("FAIL first_fault: got ep=%b ec=%0d f=%b want 1/1/1",
                     err_pulse, err_cnt, fail);
        end
        n_cmp++;
        if (first_exp_q !== 4'b1010 || first_act_q !== 4'b1011) begin
            n_bad++;
            $display("FAIL first_capture: got exp=%b act=%b want 1010/1011",
                     first_exp_q, first_act_q);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b1010, 1'b0);
        n_cmp++;
        if (err_pulse !== 1'b0 || err_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL pulse_width: got ep=%b ec=%0d want 0/1", err_pulse, err_cnt);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b0000, 1'b0);
        n_cmp++;
        if (err_cnt !== 8'd2 || first_exp_q !== 4'b1010 || first_act_q !== 4'b1011) begin
            n_bad++;
            $display("FAIL second_fault: got ec=%0d exp=%b act=%b want 2/1010/1011",
                     err_cnt, first_exp_q, first_act_q);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'bxxxx, 1'b0);
        n_cmp++;
        if (err_pulse !== 1'b1 || err_cnt !== 8'd3) begin
            n_bad++;
            $display("FAIL x_fault: got ep=%b ec=%0d want 1/3", err_pulse, err_cnt);
        end
    endtask

    task automatic test_saturate();
        clr();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, LD, 4'b1010, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b0101, 1'b0);
        end
        n_cmp++;
        if (err_cnt2 !== 2'd3 || fail2 !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sat: got ec=%0d f=%b want 3/1", err_cnt2, fail2);
        end
        n_cmp++;
        if (err_cnt !== 8'd5) begin
            n_bad++;
            $display("FAIL err_count5: got %0d want 5", err_cnt);
        end
    endtask

    task automatic test_reset_and_clear();
        clr();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, LD, 4'b1100, 4'b0000, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, SH, 4'b0000, 4'b1100, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({chk_active, err_pulse, fail, err_cnt, chk_cnt, first_exp_q, first_act_q} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got act=%b ep=%b f=%b ec=%0d cc=%0d want all 0",
                     chk_active, err_pulse, fail, err_cnt, chk_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, SH, 4'b0000, 4'b1111, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b1111, 1'b1);
        n_cmp++;
        if (chk_active !== 1'b0 || err_cnt !== 8'd0 || chk_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL unsync_after_rst: got act=%b ec=%0d cc=%0d want 0/0/0",
                     chk_active, err_cnt, chk_cnt);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, LD, 4'b0110, 4'b0000, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b1001, 1'b0);
        chk_clr = 1'b0;
        n_cmp++;
        if ({chk_active, err_pulse, fail, err_cnt, chk_cnt} !== '0) begin
            n_bad++;
            $display("FAIL clr_wins: got act=%b ep=%b f=%b ec=%0d cc=%0d want all 0",
                     chk_active, err_pulse, fail, err_cnt, chk_cnt);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HO, 4'b0000, 4'b1001, 1'b0);
        n_cmp++;
        if (err_pulse !== 1'b0 || chk_active !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_unsync: got ep=%b act=%b want 0/0", err_pulse, chk_active);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, LD, 4'b0110, 4'b0000, 1'b0);
        n_cmp++;
        if (chk_active !== 1'b1) begin
            n_bad++;
            $display("FAIL resync: got %b want 1", chk_active);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_shift_left();
        test_rotate_right();
        test_fault_capture();
        test_saturate();
        test_reset_and_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
